// File: rtl/fifo_ctrl.sv
// FIFO control stage: gates push/pop requests into memory strobes, owns the
// read/write pointers, occupancy count, status flags and a sticky error state.
module fifo_ctrl #(
    parameter int MEM_SIZE  = 4,
    parameter int WORD_SIZE = 6,
    parameter int PTR_L     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [PTR_L-1:0] umbral_alto,
    input  logic [PTR_L-1:0] umbral_bajo,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push,
    output logic             pop,
    output logic [PTR_L-1:0] wr_ptr,
    output logic [PTR_L-1:0] rd_ptr,
    output logic [PTR_L-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             error,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    localparam logic [PTR_L-1:0] LAST_IDX = PTR_L'(MEM_SIZE - 1);
    localparam logic [PTR_L-1:0] DEPTH    = PTR_L'(MEM_SIZE);

    logic [1:0]       state;
    logic [PTR_L-1:0] umbral_alto_reg;
    logic [PTR_L-1:0] umbral_bajo_reg;
    logic [PTR_L-1:0] count_nxt;
    logic             running;
    logic             overflow;
    logic             underflow;
    logic             fault;
    logic             commit_push;
    logic             commit_pop;

    // Word width only matters to the memory beside this block.
    logic word_size_unused;
    assign word_size_unused = (WORD_SIZE > 0);

    function automatic logic [PTR_L-1:0] ptr_inc(input logic [PTR_L-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign state_dbg    = state;
    assign full         = (count == DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= umbral_alto_reg);
    assign almost_empty = (count <= umbral_bajo_reg);

    // Strobes are plain combinational qualifications of the requests: the memory
    // acts at wr_ptr/rd_ptr on the same edge a strobe is high. init overrides.
    assign running   = ((state == S_IDLE) || (state == S_ACTIVE)) && !init;
    assign push      = running & push_req & (~full | pop_req);
    assign pop       = running & pop_req & ~empty;
    assign overflow  = running & push_req & full & ~pop_req;
    assign underflow = running & pop_req & empty;
    assign fault     = overflow | underflow;

    // A faulting cycle commits nothing, even if the push strobe was raised.
    assign commit_push = push & ~fault;
    assign commit_pop  = pop & ~fault;

    always_comb begin
        count_nxt = count;
        if (commit_push && !commit_pop) begin
            count_nxt = count + 1'b1;
        end else if (commit_pop && !commit_push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_INIT;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            error           <= 1'b0;
            umbral_alto_reg <= LAST_IDX;
            umbral_bajo_reg <= PTR_L'(1);
        end else if (init) begin
            state           <= S_INIT;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            error           <= 1'b0;
            umbral_alto_reg <= umbral_alto;
            umbral_bajo_reg <= umbral_bajo;
        end else begin
            case (state)
                S_INIT: begin
                    state  <= S_IDLE;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end
                S_IDLE, S_ACTIVE: begin
                    if (fault) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        if (commit_push) wr_ptr <= ptr_inc(wr_ptr);
                        if (commit_pop)  rd_ptr <= ptr_inc(rd_ptr);
                        count <= count_nxt;
                        state <= (count_nxt == '0) ? S_IDLE : S_ACTIVE;
                    end
                end
                S_ERROR: begin
                    error <= 1'b1;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl: a queue-based occupancy model predicts every
// output each cycle, with directed sequences pinning literal expectations.
module tb_fifo_ctrl;

    localparam int MEM_SIZE  = 4;
    localparam int WORD_SIZE = 6;
    localparam int PTR_L     = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic [PTR_L-1:0] umbral_alto;
    logic [PTR_L-1:0] umbral_bajo;
    logic             push_req;
    logic             pop_req;
    logic             push;
    logic             pop;
    logic [PTR_L-1:0] wr_ptr;
    logic [PTR_L-1:0] rd_ptr;
    logic [PTR_L-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             error;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    fifo_ctrl #(.MEM_SIZE(MEM_SIZE), .WORD_SIZE(WORD_SIZE), .PTR_L(PTR_L)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .push_req(push_req), .pop_req(pop_req),
        .push(push), .pop(pop), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 = initialising, 1 = running, 2 = errored.
    // exp_q holds the slot address of every word currently stored, oldest first.
    logic [PTR_L-1:0] exp_q[$];
    int  m_mode;
    int  m_wr;
    int  m_rd;
    int  m_ua;
    int  m_ub;
    int  m_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        int  occ;
        if (reset) begin
            m_mode = 0; exp_q.delete(); m_wr = 0; m_rd = 0; m_err = 0;
            m_ua = MEM_SIZE - 1; m_ub = 1;
        end else if (init) begin
            m_mode = 0; exp_q.delete(); m_wr = 0; m_rd = 0; m_err = 0;
            m_ua = int'(umbral_alto); m_ub = int'(umbral_bajo);
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            occ = exp_q.size();
            if ((push_req && occ == MEM_SIZE && !pop_req) || (pop_req && occ == 0)) begin
                m_mode = 2;
                m_err  = 1;
            end else begin
                if (pop_req && occ > 0) begin
                    void'(exp_q.pop_front());
                    m_rd = (m_rd + 1) % MEM_SIZE;
                end
                if (push_req && (occ < MEM_SIZE || pop_req)) begin
                    exp_q.push_back(PTR_L'(m_wr));
                    m_wr = (m_wr + 1) % MEM_SIZE;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int occ;
        int run;
        int e_full;
        int e_empty;
        int e_push;
        int e_pop;
        int e_state;
        occ     = exp_q.size();
        run     = (m_mode == 1 && !reset && !init) ? 1 : 0;
        e_full  = (occ == MEM_SIZE) ? 1 : 0;
        e_empty = (occ == 0) ? 1 : 0;
        e_push  = (run == 1 && push_req && (e_full == 0 || pop_req)) ? 1 : 0;
        e_pop   = (run == 1 && pop_req && e_empty == 0) ? 1 : 0;
        if (m_mode == 0)      e_state = 0;
        else if (m_mode == 2) e_state = 3;
        else                  e_state = (occ == 0) ? 1 : 2;
        check("push", int'(push), e_push);
        check("pop", int'(pop), e_pop);
        check("count", int'(count), occ);
        check("wr_ptr", int'(wr_ptr), m_wr);
        check("rd_ptr", int'(rd_ptr), m_rd);
        check("full", int'(full), e_full);
        check("empty", int'(empty), e_empty);
        check("almost_full", int'(almost_full), (occ >= m_ua) ? 1 : 0);
        check("almost_empty", int'(almost_empty), (occ <= m_ub) ? 1 : 0);
        check("error", int'(error), m_err);
        check("state", int'(state_dbg), e_state);
        if (e_pop == 1 && occ > 0) check("pop_addr", int'(rd_ptr), int'(exp_q[0]));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic pu, input logic po);
        push_req = pu;
        pop_req  = po;
        @(posedge clk); #1;
    endtask

    task automatic do_init(input int ua, input int ub);
        init = 1'b1;
        umbral_alto = PTR_L'(ua);
        umbral_bajo = PTR_L'(ub);
        push_req = 1'b0;
        pop_req  = 1'b0;
        @(posedge clk); #1;
        init = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bias;
        reset = 1'b1; init = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        umbral_alto = '0; umbral_bajo = '0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("lit_rst_count", int'(count), 0);
        check("lit_rst_empty", int'(empty), 1);
        check("lit_rst_ae", int'(almost_empty), 1);
        check("lit_rst_af", int'(almost_full), 0);
        check("lit_rst_push", int'(push), 0);

        do_init(3, 1);
        check("lit_idle", int'(state_dbg), 1);
        check("lit_idle_ptrs", int'(wr_ptr) + int'(rd_ptr), 0);

        repeat (4) cyc(1'b1, 1'b0);
        check("lit_fill_count", int'(count), 4);
        check("lit_fill_full", int'(full), 1);
        check("lit_fill_af", int'(almost_full), 1);
        check("lit_fill_ae", int'(almost_empty), 0);
        check("lit_fill_wr", int'(wr_ptr), 0);
        check("lit_full_push", int'(push), 0);

        @(posedge clk); #1;
        check("lit_ovf_error", int'(error), 1);
        check("lit_ovf_state", int'(state_dbg), 3);
        check("lit_ovf_count", int'(count), 4);
        push_req = 1'b0; pop_req = 1'b1;
        #1 check("lit_err_pop", int'(pop), 0);
        @(posedge clk); #1;
        check("lit_err_rd", int'(rd_ptr), 0);
        do_init(3, 1);
        check("lit_reinit_error", int'(error), 0);
        check("lit_reinit_count", int'(count), 0);

        repeat (4) cyc(1'b1, 1'b0);
        push_req = 1'b1; pop_req = 1'b1;
        #1 check("lit_both_strobes", int'(push) + int'(pop), 2);
        repeat (3) begin @(posedge clk); #1; end
        check("lit_both_count", int'(count), 4);
        check("lit_both_wr", int'(wr_ptr), 3);
        check("lit_both_rd", int'(rd_ptr), 3);
        repeat (4) cyc(1'b0, 1'b1);
        check("lit_drain_count", int'(count), 0);
        check("lit_drain_state", int'(state_dbg), 1);

        push_req = 1'b1; pop_req = 1'b1;
        #1 check("lit_empty_push", int'(push), 1);
        check("lit_empty_pop", int'(pop), 0);
        @(posedge clk); #1;
        check("lit_unf_error", int'(error), 1);
        check("lit_unf_count", int'(count), 0);
        check("lit_unf_wr", int'(wr_ptr), 3);

        do_init(3, 1);
        repeat (2) cyc(1'b1, 1'b0);
        check("lit_mid_count", int'(count), 2);
        check("lit_mid_push", int'(push), 1);
        #1 reset = 1'b1;
        #1 check("lit_mid_rst_push", int'(push), 0);
        check("lit_mid_rst_count", int'(count), 0);
        check("lit_mid_rst_wr", int'(wr_ptr), 0);
        check("lit_mid_rst_state", int'(state_dbg), 0);
        @(posedge clk); #1;
        reset = 1'b0; push_req = 1'b0;
        do_init(3, 1);

        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 16 == 0) bias = 25 * int'($urandom_range(1, 3));
            push_req = ($urandom_range(0, 99) < bias);
            pop_req  = ($urandom_range(0, 99) < (100 - bias));
            init     = (m_err == 1 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
            if (init) begin
                umbral_alto = PTR_L'($urandom_range(0, 7));
                umbral_bajo = PTR_L'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 7));
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        init = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
